pc_stack_sequencer: RTL
=======================

# pc_stack_sequencer

Multi-cycle controller that sequences CALL, RET, RTI and interrupt entry on the 16-bit data memory on behalf of the pipeline. It owns the stack pointer, splits the 32-bit PC and the flags into 16-bit stack words, and stalls fetch/decode while it runs. After the last stack access it issues a single PC (and flags) load. It sits beside Decode, which supplies the request pulses and arbitrates the memory port toward it.

## Interface

Parameters:
- SP_INIT, 16'hFFFF, stack pointer reset value (top of stack, grows downward)
- FLAG_W, 3, flags width (Z, N, C)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- call_req  in  1  CALL decoded this cycle
- ret_req  in  1  RET decoded this cycle
- rti_req  in  1  RTI decoded this cycle
- int_req  in  1  interrupt pending (level; held until int_ack)
- target_pc  in  32  CALL destination
- return_pc  in  32  PC to save (next instruction)
- int_vector  in  32  interrupt handler PC
- flags_in  in  FLAG_W  current CCR
- mem_ready  in  1  memory accepted/finished current access
- mem_rdata  in  16  read data, valid when mem_ready=1
- stall  out  1  freeze fetch/decode
- int_ack  out  1  one-cycle pulse on interrupt acceptance
- mem_req  out  1  stack access request
- mem_we  out  1  1=push write, 0=pop read
- mem_addr  out  16  stack address
- mem_wdata  out  16  push data
- pc_load  out  1  one-cycle PC load strobe
- pc_value  out  32  PC to load, valid with pc_load
- flags_load  out  1  one-cycle CCR restore strobe (RTI only)
- flags_out  out  FLAG_W  restored flags
- sp  out  16  current stack pointer
- stack_err  out  1  sticky over/underflow flag

## Operation

- States: IDLE, PUSH_HI, PUSH_LO, PUSH_FLG, POP_FLG, POP_LO, POP_HI, LOAD.
- IDLE accepts at most one request per edge; priority int_req > rti_req > ret_req > call_req; lower ones dropped. In IDLE, return_pc/target_pc/int_vector/flags_in are latched.
- Sequences:
  - CALL: PUSH_HI → PUSH_LO → LOAD(target).
  - INT: PUSH_HI → PUSH_LO → PUSH_FLG → LOAD(vector); int_ack pulses on the accept edge.
  - RET: POP_LO → POP_HI → LOAD(popped).
  - RTI: POP_FLG → POP_LO → POP_HI → LOAD(popped, flags_load=1).
- Push: mem_addr=SP, mem_we=1; on mem_ready, SP ← SP−1.
- Pop: mem_addr=SP+1, mem_we=0; on mem_ready, SP ← SP+1 and the word is captured.
- Flags occupy mem_wdata[FLAG_W−1:0]; upper bits are 0.
- A state advances only on an edge with mem_ready=1; mem_req and the address/data stay stable until then.
- LOAD: pc_load=1 (flags_load for RTI) for exactly one cycle, then IDLE.
- SP arithmetic is 16-bit modulo.
- Push with SP=0 or pop with SP=SP_INIT sets stack_err. The access still proceeds and SP wraps; only reset clears stack_err.
- Requests arriving while not IDLE are ignored. Decode holds them, since stall is high.

## Timing

- Reset (async, reset=0) puts: state IDLE, SP=SP_INIT, every output 0, pc_value 0, latches 0.
- Reset mid-sequence aborts: no pc_load is issued, SP returns to SP_INIT, and completed pushes are abandoned.
- stall = (state≠IDLE) | (state==IDLE & any request). It is combinational, so it rises in the request cycle and falls in the cycle after LOAD.
- Latency with zero-wait memory (mem_ready tied 1), accept edge = cycle 0: CALL/RET pc_load in cycle 3, INT/RTI pc_load in cycle 4.
- Each wait cycle (mem_ready=0) adds exactly one cycle.
- mem_req is low in IDLE and LOAD.

## Test plan

- CALL, SP=FFFF, return_pc=0x00000010, target=0x00001234, mem_ready=1 → writes mem[FFFF]=0x0000, mem[FFFE]=0x0010; SP=FFFD; pc_load with 0x00001234 in cycle 3; stall high cycles 0–3.
- RET after the CALL above, memory returning stored words → reads FFFE then FFFF; SP=FFFF; pc_value=0x00000010.
- int_req, call_req and ret_req in the same cycle, flags=3'b101, vector=0x00000200 → only INT runs; int_ack pulses once; writes 0x0000, 0x0010, 0x0005; SP=FFFC; pc_load 0x00000200. A following RTI restores flags_out=3'b101 and pc 0x00000010 with SP=FFFF.
- CALL with mem_ready low for 2 cycles on PUSH_LO → mem_addr/mem_wdata held stable; pc_load delayed to cycle 5.
- RET at SP=FFFF → stack_err=1 and stays set; SP wraps to 0x0000 and then 0x0001.
- reset asserted during PUSH_LO of INT → outputs 0 immediately; no pc_load; SP=FFFF after reset release; the next CALL runs normally.

Source files
------------

// File: rtl/pc_stack_sequencer.sv
// -----------------------------------------------------------------------------
// pc_stack_sequencer
//
// Multi-cycle controller that runs CALL, RET, RTI and interrupt entry against
// the 16-bit data memory. It owns the stack pointer (grows downward), splits
// the 32-bit PC and the flags into 16-bit stack words, holds fetch/decode via
// stall while busy, and finishes every sequence with a single PC (and, for
// RTI, flags) load strobe.
//
// Stack frame layout, from the higher address down:
//   PC[31:16], PC[15:0], {zeros, flags}   (flags word only for interrupts)
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   call_req/ret_req/rti_req/int_req   request inputs from Decode
//   target_pc, return_pc, int_vector, flags_in   operands latched in IDLE
//   mem_ready, mem_rdata                memory handshake / read data
//   stall, int_ack                      pipeline control
//   mem_req, mem_we, mem_addr, mem_wdata  stack access port
//   pc_load, pc_value, flags_load, flags_out  final load strobes and values
//   sp, stack_err                       stack pointer, sticky over/underflow
// -----------------------------------------------------------------------------
module pc_stack_sequencer #(
  parameter logic [15:0] SP_INIT = 16'hFFFF,
  parameter int unsigned FLAG_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic              rti_req,
  input  logic              int_req,
  input  logic [31:0]       target_pc,
  input  logic [31:0]       return_pc,
  input  logic [31:0]       int_vector,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              mem_ready,
  input  logic [15:0]       mem_rdata,
  output logic              stall,
  output logic              int_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              pc_load,
  output logic [31:0]       pc_value,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_out,
  output logic [15:0]       sp,
  output logic              stack_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH_HI  = 3'd1,
    S_PUSH_LO  = 3'd2,
    S_PUSH_FLG = 3'd3,
    S_POP_FLG  = 3'd4,
    S_POP_LO   = 3'd5,
    S_POP_HI   = 3'd6,
    S_LOAD     = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    OP_CALL = 2'd0,
    OP_INT  = 2'd1,
    OP_RET  = 2'd2,
    OP_RTI  = 2'd3
  } op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [15:0]         sp_q, sp_d;
  logic                err_q, err_d;
  logic [31:0]         ret_pc_q, ret_pc_d;     // PC to push
  logic [31:0]         dest_pc_q, dest_pc_d;   // CALL target or interrupt vector
  logic [FLAG_W-1:0]   flags_lat_q, flags_lat_d;
  logic [15:0]         pop_lo_q, pop_lo_d;
  logic [31:0]         pc_value_q, pc_value_d;
  logic [FLAG_W-1:0]   flags_out_q, flags_out_d;
  logic                is_push_s;
  logic                is_pop_s;
  logic                any_req_s;

  assign is_push_s = (state_q == S_PUSH_HI) || (state_q == S_PUSH_LO) ||
                     (state_q == S_PUSH_FLG);
  assign is_pop_s  = (state_q == S_POP_FLG) || (state_q == S_POP_LO) ||
                     (state_q == S_POP_HI);
  assign any_req_s = call_req | ret_req | rti_req | int_req;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_CALL;
      sp_q        <= SP_INIT;
      err_q       <= 1'b0;
      ret_pc_q    <= 32'd0;
      dest_pc_q   <= 32'd0;
      flags_lat_q <= '0;
      pop_lo_q    <= 16'd0;
      pc_value_q  <= 32'd0;
      flags_out_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sp_q        <= sp_d;
      err_q       <= err_d;
      ret_pc_q    <= ret_pc_d;
      dest_pc_q   <= dest_pc_d;
      flags_lat_q <= flags_lat_d;
      pop_lo_q    <= pop_lo_d;
      pc_value_q  <= pc_value_d;
      flags_out_q <= flags_out_d;
    end
  end

  // Next-state, operand capture, SP update and error detection
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sp_d        = sp_q;
    err_d       = err_q;
    ret_pc_d    = ret_pc_q;
    dest_pc_d   = dest_pc_q;
    flags_lat_d = flags_lat_q;
    pop_lo_d    = pop_lo_q;
    pc_value_d  = pc_value_q;
    flags_out_d = flags_out_q;

    case (state_q)
      S_IDLE: begin
        // Operands track the inputs every idle cycle, so the values present
        // on the accept edge are the ones that stick.
        ret_pc_d    = return_pc;
        dest_pc_d   = int_req ? int_vector : target_pc;
        flags_lat_d = flags_in;
        if (int_req) begin
          op_d    = OP_INT;
          state_d = S_PUSH_HI;
        end else if (rti_req) begin
          op_d    = OP_RTI;
          state_d = S_POP_FLG;
        end else if (ret_req) begin
          op_d    = OP_RET;
          state_d = S_POP_LO;
        end else if (call_req) begin
          op_d    = OP_CALL;
          state_d = S_PUSH_HI;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PUSH_HI: begin
        if (mem_ready) state_d = S_PUSH_LO;
        else           state_d = S_PUSH_HI;
      end
      S_PUSH_LO: begin
        if (mem_ready) begin
          if (op_q == OP_INT) begin
            state_d = S_PUSH_FLG;
          end else begin
            state_d    = S_LOAD;
            pc_value_d = dest_pc_q;
          end
        end else begin
          state_d = S_PUSH_LO;
        end
      end
      S_PUSH_FLG: begin
        if (mem_ready) begin
          state_d    = S_LOAD;
          pc_value_d = dest_pc_q;
        end else begin
          state_d = S_PUSH_FLG;
        end
      end
      S_POP_FLG: begin
        if (mem_ready) begin
          state_d     = S_POP_LO;
          flags_out_d = mem_rdata[FLAG_W-1:0];
        end else begin
          state_d = S_POP_FLG;
        end
      end
      S_POP_LO: begin
        if (mem_ready) begin
          state_d  = S_POP_HI;
          pop_lo_d = mem_rdata;
        end else begin
          state_d = S_POP_LO;
        end
      end
      S_POP_HI: begin
        if (mem_ready) begin
          state_d    = S_LOAD;
          pc_value_d = {mem_rdata, pop_lo_q};
        end else begin
          state_d = S_POP_HI;
        end
      end
      S_LOAD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The access completes even on over/underflow; SP simply wraps.
    if (mem_ready && is_push_s) begin
      sp_d = sp_q - 16'd1;
      if (sp_q == 16'd0) err_d = 1'b1;
      else               err_d = err_q;
    end else if (mem_ready && is_pop_s) begin
      sp_d = sp_q + 16'd1;
      if (sp_q == SP_INIT) err_d = 1'b1;
      else                 err_d = err_q;
    end else begin
      sp_d = sp_q;
    end
  end

  // Output decode from the registered state
  always_comb begin
    stall      = 1'b0;
    int_ack    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 16'd0;
    mem_wdata  = 16'd0;
    pc_load    = 1'b0;
    flags_load = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall   = any_req_s;
        int_ack = int_req;
      end
      S_PUSH_HI: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = ret_pc_q[31:16];
      end
      S_PUSH_LO: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = ret_pc_q[15:0];
      end
      S_PUSH_FLG: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = {{(16-FLAG_W){1'b0}}, flags_lat_q};
      end
      S_POP_FLG, S_POP_LO, S_POP_HI: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = sp_q + 16'd1;
      end
      S_LOAD: begin
        stall      = 1'b1;
        pc_load    = 1'b1;
        flags_load = (op_q == OP_RTI);
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign pc_value  = pc_value_q;
  assign flags_out = flags_out_q;
  assign sp        = sp_q;
  assign stack_err = err_q;

endmodule
